// File: rtl/if_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and a
// synchronous instruction memory (slave) with a 1-cycle read latency.
interface if_stage_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_rdEn;
  logic [31:0]         imem_rdata;

  modport master (output imem_addr, output imem_rdEn, input imem_rdata);
  modport slave  (input imem_addr, input imem_rdEn, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, hazard stall and taken-branch redirect.
// Optional IF_PERF_CNT_EN adds saturating fetch/stall/flush performance counters.
module if_stage #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]         NOP_INST = 32'hF000_0000
) (
  input  logic                clk,
  input  logic                reset,
  if_stage_if.master          imem,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [15:0]         branch_target,
  output logic [31:0]         IF_ID_inst,
  output logic [PC_WIDTH-1:0] IF_ID_pc,
  output logic                IF_ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [31:0]         hold_inst_q, hold_inst_d;
  logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]         inst_d;
  logic [PC_WIDTH-1:0] ifid_pc_d;
  logic                valid_d;
  logic                rd_en;
  logic [PC_WIDTH-1:0] addr;
  logic                redirect;
  logic [PC_WIDTH-1:0] target;

  // Branch immediate is a byte address; force word alignment before use.
  assign target = PC_WIDTH'({branch_target[15:2], 2'b00});

  assign imem.imem_addr = addr;
  assign imem.imem_rdEn = rd_en;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    inst_d      = IF_ID_inst;
    ifid_pc_d   = IF_ID_pc;
    valid_d     = IF_ID_valid;
    rd_en       = 1'b0;
    addr        = pc_q;
    redirect    = 1'b0;

    unique case (state_q)
      BOOT: begin
        rd_en    = 1'b1;
        rsp_pc_d = pc_q;
        pc_d     = pc_q + PC_STEP;
        state_d  = RUN;
      end
      RUN: begin
        if (stall) begin
          // Park the response already in flight so it is not lost.
          hold_inst_d = imem.imem_rdata;
          hold_pc_d   = rsp_pc_q;
          state_d     = HOLD;
        end else if (branch_taken) begin
          redirect = 1'b1;
        end else begin
          rd_en     = 1'b1;
          inst_d    = imem.imem_rdata;
          ifid_pc_d = rsp_pc_q;
          valid_d   = 1'b1;
          rsp_pc_d  = pc_q;
          pc_d      = pc_q + PC_STEP;
        end
      end
      HOLD: begin
        if (!stall) begin
          if (branch_taken) begin
            redirect = 1'b1;
          end else begin
            rd_en       = 1'b1;
            inst_d      = hold_inst_q;
            ifid_pc_d   = hold_pc_q;
            valid_d     = 1'b1;
            rsp_pc_d    = pc_q;
            pc_d        = pc_q + PC_STEP;
            hold_inst_d = NOP_INST;
            hold_pc_d   = '0;
            state_d     = RUN;
          end
        end
      end
      default: state_d = BOOT;
    endcase

    // Redirect squashes the wrong-path slot and restarts fetch at the target.
    if (redirect) begin
      rd_en       = 1'b1;
      addr        = target;
      rsp_pc_d    = target;
      pc_d        = target + PC_STEP;
      inst_d      = NOP_INST;
      ifid_pc_d   = '0;
      valid_d     = 1'b0;
      hold_inst_d = NOP_INST;
      hold_pc_d   = '0;
      state_d     = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= '0;
      hold_inst_q <= NOP_INST;
      hold_pc_q   <= '0;
      IF_ID_inst  <= NOP_INST;
      IF_ID_pc    <= '0;
      IF_ID_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      IF_ID_inst  <= inst_d;
      IF_ID_pc    <= ifid_pc_d;
      IF_ID_valid <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_ld;
  logic stall_cyc;

  assign fetch_ld  = (state_q != BOOT) && !stall && !branch_taken;
  assign stall_cyc = (state_q != BOOT) && stall;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (fetch_ld && (perf_fetch_cnt != '1))  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_cyc && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect && (perf_flush_cnt != '1))  perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: free-run, stall, redirect, stall+branch,
// reset mid-HOLD and mid-redirect, plus a second instance exercising PC wrap-around.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'hF000_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [31:0] IF_ID_inst, w_inst;
  logic [31:0] IF_ID_pc, w_pc;
  logic        IF_ID_valid, w_valid;
  int          n_chk;
  int          n_pass;

  if_stage_if #(.PC_WIDTH(32)) bus ();
  if_stage_if #(.PC_WIDTH(32)) w_bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] pf_fetch, pf_stall, pf_flush, w_pf_fetch, w_pf_stall, w_pf_flush;
`endif

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (bus.master),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .IF_ID_inst    (IF_ID_inst),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_valid   (IF_ID_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (pf_fetch),
    .perf_stall_cnt (pf_stall),
    .perf_flush_cnt (pf_flush)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk           (clk),
    .reset         (reset),
    .imem          (w_bus.master),
    .stall         (1'b0),
    .branch_taken  (1'b0),
    .branch_target (16'h0000),
    .IF_ID_inst    (w_inst),
    .IF_ID_pc      (w_pc),
    .IF_ID_valid   (w_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (w_pf_fetch),
    .perf_stall_cnt (w_pf_stall),
    .perf_flush_cnt (w_pf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word at byte address a holds a>>2; idle cycles return garbage.
  always @(posedge clk) begin
    bus.imem_rdata   <= bus.imem_rdEn   ? (bus.imem_addr >> 2)   : 32'hDEAD_BEEF;
    w_bus.imem_rdata <= w_bus.imem_rdEn ? (w_bus.imem_addr >> 2) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one cycle's inputs, check the fetch request, then clock.
  task automatic cyc(input logic s, input logic b, input logic [15:0] t,
                     input logic [31:0] exp_addr, input logic exp_en);
    stall = s;
    branch_taken = b;
    branch_target = t;
    #1;
    check("imem_addr", bus.imem_addr, exp_addr);
    check("imem_rdEn", 32'(bus.imem_rdEn), 32'(exp_en));
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic v, input logic [31:0] inst,
                      input logic [31:0] pc);
    check({tag, ".valid"}, 32'(IF_ID_valid), 32'(v));
    check({tag, ".inst"}, IF_ID_inst, inst);
    check({tag, ".pc"}, IF_ID_pc, pc);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    ifid("reset", 1'b0, NOP, 32'h0);
    check("reset_addr", bus.imem_addr, 32'h0);
    reset = 1'b0;

    // Free run and wrap-around instance
    check("wrap_addr0", w_bus.imem_addr, 32'hFFFF_FFF8);
    cyc(0, 0, 16'h0, 32'h0, 1);
    ifid("boot_bubble", 1'b0, NOP, 32'h0);
    check("wrap_addr1", w_bus.imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 16'h0, 32'h4, 1);
    ifid("run0", 1'b1, 32'h0, 32'h0);
    check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    check("wrap_addr2", w_bus.imem_addr, 32'h0);
    cyc(0, 0, 16'h0, 32'h8, 1);
    ifid("run1", 1'b1, 32'h1, 32'h4);
    check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 16'h0, 32'hC, 1);
    ifid("run2", 1'b1, 32'h2, 32'h8);
    check("wrap_pc2", w_pc, 32'h0);
    check("wrap_inst2", w_inst, 32'h0);

    // Three-cycle stall while IF_ID_pc = 8
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 16'h0, 32'h10, 0);
      ifid("stall_hold", 1'b1, 32'h2, 32'h8);
    end
    cyc(0, 0, 16'h0, 32'h10, 1);
    ifid("unstall0", 1'b1, 32'h3, 32'hC);
    cyc(0, 0, 16'h0, 32'h14, 1);
    ifid("unstall1", 1'b1, 32'h4, 32'h10);

    // Redirect from RUN, target 0x42 aligns to 0x40
    cyc(0, 1, 16'h0042, 32'h40, 1);
    ifid("br_bubble", 1'b0, NOP, 32'h0);
    cyc(0, 0, 16'h0, 32'h44, 1);
    ifid("br_target", 1'b1, 32'h10, 32'h40);

    // Stall wins over simultaneous branch
    cyc(1, 1, 16'h0100, 32'h48, 0);
    ifid("stall_br", 1'b1, 32'h10, 32'h40);
    cyc(0, 0, 16'h0, 32'h48, 1);
    ifid("stall_br_rel", 1'b1, 32'h11, 32'h44);
    cyc(0, 1, 16'h0100, 32'h100, 1);
    ifid("br2_bubble", 1'b0, NOP, 32'h0);
    cyc(0, 0, 16'h0, 32'h104, 1);
    ifid("br2_target", 1'b1, 32'h40, 32'h100);

    // Branch on the cycle a 2-cycle stall releases; target checks zero-extension
    cyc(1, 0, 16'h0, 32'h108, 0);
    cyc(1, 0, 16'h0, 32'h108, 0);
    ifid("hold2", 1'b1, 32'h40, 32'h100);
    cyc(0, 1, 16'hFFFF, 32'hFFFC, 1);
    ifid("hold_br_bubble", 1'b0, NOP, 32'h0);
    cyc(0, 0, 16'h0, 32'h1_0000, 1);
    ifid("hold_br_target", 1'b1, 32'h3FFF, 32'hFFFC);

    // Reset during HOLD
    cyc(1, 0, 16'h0, 32'h1_0004, 0);
    reset = 1'b1;
    cyc(1, 0, 16'h0, 32'h1_0004, 0);
    ifid("rst_hold", 1'b0, NOP, 32'h0);
    reset = 1'b0;
    cyc(0, 0, 16'h0, 32'h0, 1);
    cyc(0, 0, 16'h0, 32'h4, 1);
    ifid("rst_hold_resume0", 1'b1, 32'h0, 32'h0);
    cyc(0, 0, 16'h0, 32'h8, 1);
    ifid("rst_hold_resume1", 1'b1, 32'h1, 32'h4);

    // Reset during a redirect cycle
    reset = 1'b1;
    cyc(0, 1, 16'h0080, 32'h80, 1);
    ifid("rst_br", 1'b0, NOP, 32'h0);
    reset = 1'b0;
    cyc(0, 0, 16'h0, 32'h0, 1);
    cyc(0, 0, 16'h0, 32'h4, 1);
    ifid("rst_br_resume", 1'b1, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
